traffic_ctrl: RTL



---
 rtl/traffic_pkg.sv | 46 ++++
 rtl/traffic_ctrl_phase_timer.sv | 28 ++
 rtl/traffic_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared types, default phase durations and light decode for the intersection controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    RED    = 2'b00,
    YELLOW = 2'b01,
    GREEN  = 2'b10
  } light_t;

  typedef enum logic [2:0] {
    HG,
    HY,
    AR1,
    FG,
    FY,
    AR2,
    FL
  } state_t;

  localparam int CNT_W_DEF = 28;
  localparam int T_HG_DEF  = 250_000_000;
  localparam int T_HY_DEF  = 50_000_000;
  localparam int T_AR_DEF  = 25_000_000;
  localparam int T_FG_DEF  = 150_000_000;
  localparam int T_FY_DEF  = 50_000_000;
  localparam int T_FL_DEF  = 25_000_000;

  function automatic light_t hwy_of(input state_t s, input logic tog);
    case (s)
      HG:      hwy_of = GREEN;
      HY:      hwy_of = YELLOW;
      FL:      hwy_of = tog ? YELLOW : RED;
      default: hwy_of = RED;
    endcase
  endfunction

  function automatic light_t farm_of(input state_t s, input logic tog);
    case (s)
      FG:      farm_of = GREEN;
      FY:      farm_of = YELLOW;
      FL:      farm_of = tog ? YELLOW : RED;
      default: farm_of = RED;
    endcase
  endfunction

endpackage

// File: rtl/traffic_ctrl_phase_timer.sv
// Reloadable phase down-counter: load wins, otherwise decrement and stick at zero.
module phase_timer #(
  parameter int               CNT_W   = 28,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - ONE;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/traffic_ctrl.sv
// Highway/farm-road sequencer: Moore FSM owning one phase timer, plus flash mode.
module traffic_ctrl
  import traffic_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int T_HG  = T_HG_DEF,
  parameter int T_HY  = T_HY_DEF,
  parameter int T_AR  = T_AR_DEF,
  parameter int T_FG  = T_FG_DEF,
  parameter int T_FY  = T_FY_DEF,
  parameter int T_FL  = T_FL_DEF
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   car_farm,
  input  logic   flash_n,
  output light_t hwy_light,
  output light_t farm_light,
  output logic   phase_start
);

  localparam logic [CNT_W-1:0] LD_HG = CNT_W'(T_HG - 1);
  localparam logic [CNT_W-1:0] LD_HY = CNT_W'(T_HY - 1);
  localparam logic [CNT_W-1:0] LD_AR = CNT_W'(T_AR - 1);
  localparam logic [CNT_W-1:0] LD_FG = CNT_W'(T_FG - 1);
  localparam logic [CNT_W-1:0] LD_FY = CNT_W'(T_FY - 1);
  localparam logic [CNT_W-1:0] LD_FL = CNT_W'(T_FL - 1);

  state_t           state_q, state_d;
  logic             toggle_q, toggle_d;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] count;
  logic             expired;

  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (LD_HG)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .expired  (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HG;
      toggle_q    <= 1'b0;
      hwy_light   <= GREEN;
      farm_light  <= RED;
      phase_start <= 1'b0;
    end else begin
      state_q     <= state_d;
      toggle_q    <= toggle_d;
      hwy_light   <= hwy_of(state_d, toggle_d);
      farm_light  <= farm_of(state_d, toggle_d);
      phase_start <= (state_d != state_q);
    end
  end

  always_comb begin
    state_d  = state_q;
    toggle_d = toggle_q;
    load     = 1'b0;
    load_val = LD_HG;

    // Flash request pre-empts every timer; flash always starts in the dark half.
    if (state_q != FL && !flash_n) begin
      state_d  = FL;
      toggle_d = 1'b0;
    end else begin
      case (state_q)
        HG:  if (expired && car_farm) state_d = HY;
        HY:  if (expired) state_d = AR1;
        AR1: if (expired) state_d = FG;
        FG:  if (expired || (!car_farm && count < LD_FG)) state_d = FY;
        FY:  if (expired) state_d = AR2;
        AR2: if (expired) state_d = HG;
        FL: begin
          if (flash_n) begin
            state_d = AR2;
          end else if (expired) begin
            toggle_d = ~toggle_q;
            load     = 1'b1;
            load_val = LD_FL;
          end
        end
        default: state_d = HG;
      endcase
    end

    if (state_d != state_q) begin
      load = 1'b1;
      case (state_d)
        HG:       load_val = LD_HG;
        HY:       load_val = LD_HY;
        FG:       load_val = LD_FG;
        FY:       load_val = LD_FY;
        FL:       load_val = LD_FL;
        default:  load_val = LD_AR;
      endcase
    end
  end

endmodule
